// File: rtl/riscv_pkg.sv
// Shared definitions for the MEM-stage load/store path.
//   MEM_* : encodings of the access size field carried down the pipeline
//   WSTRB_*: byte-enable patterns used by the store lane logic
//   lsu_state_t: bus handshake state of the load/store unit
//   is_misaligned(): access that cannot be issued as a single aligned word access
package riscv_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam logic [3:0] WSTRB_NONE    = 4'b0000;
    localparam logic [3:0] WSTRB_BYTE0   = 4'b0001;
    localparam logic [3:0] WSTRB_LO_HALF = 4'b0011;
    localparam logic [3:0] WSTRB_HI_HALF = 4'b1100;
    localparam logic [3:0] WSTRB_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StDone
    } lsu_state_t;

    // Reserved size 2'b11 is treated as misaligned so it raises the same exception.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return off[0];
            MEM_WORD: return off != 2'b00;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment for a 32-bit data port.
//   Store side: st_size_i/st_off_i/st_data_i -> replicated st_wdata_o and st_wstrb_o.
//   Load side : ld_rdata_i shifted down by ld_off_i bytes, cut to ld_size_i and
//               zero- or sign-extended (ld_unsigned_i) onto ld_data_o.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wstrb_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shifted;
    logic        ld_sign;

    // Data is replicated into every lane so the strobes alone select the target bytes.
    always_comb begin
        st_wdata_o = st_data_i;
        st_wstrb_o = WSTRB_NONE;
        case (st_size_i)
            MEM_BYTE: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_wstrb_o = WSTRB_BYTE0 << st_off_i;
            end
            MEM_HALF: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_wstrb_o = st_off_i[1] ? WSTRB_HI_HALF : WSTRB_LO_HALF;
            end
            MEM_WORD: begin
                st_wdata_o = st_data_i;
                st_wstrb_o = WSTRB_WORD;
            end
            default: ;
        endcase
    end

    assign ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_sign   = 1'b0;
        ld_data_o = ld_shifted;
        case (ld_size_i)
            MEM_BYTE: begin
                ld_sign   = ~ld_unsigned_i & ld_shifted[7];
                ld_data_o = {{24{ld_sign}}, ld_shifted[7:0]};
            end
            MEM_HALF: begin
                ld_sign   = ~ld_unsigned_i & ld_shifted[15];
                ld_data_o = {{16{ld_sign}}, ld_shifted[15:0]};
            end
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit.
//   Pipeline side : mem_to_reg_in / store_enable_in / is_unsigned_in / mem_size_in /
//                   alu_result_in / write_data_in from EX/MEM; mem_stall to the hazard
//                   unit; misaligned_exc for misaligned or reserved-size accesses.
//   Memory side   : registered dmem_req/we/addr/wdata/wstrb, accepted on dmem_ready;
//                   load word returned on dmem_rvalid/dmem_rdata.
//   Result        : load_data_out with a one-cycle load_valid pulse; bus_error pulses
//                   when the watchdog gives up on an access after TIMEOUT cycles.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_to_reg_in,
    input  logic        store_enable_in,
    input  logic        is_unsigned_in,
    input  logic [1:0]  mem_size_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    output logic        dmem_req,
    input  logic        dmem_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data_out,
    output logic        load_valid,
    output logic        mem_stall,
    output logic        misaligned_exc,
    output logic        bus_error
);

    localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_W'(TIMEOUT - 1);

    lsu_state_t           state_q;
    logic                 req_q;
    logic                 we_q;
    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           wstrb_q;
    logic [1:0]           size_q;
    logic                 uns_q;
    logic [1:0]           off_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_inc;
    logic [31:0]          ld_data_q;
    logic                 ld_valid_q;
    logic                 berr_q;

    logic                 access;
    logic                 misaligned;
    logic                 start;
    logic                 timeout;
    logic [31:0]          st_wdata;
    logic [3:0]           st_wstrb;
    logic [31:0]          ld_ext;

    assign access     = mem_to_reg_in | store_enable_in;
    assign misaligned = is_misaligned(mem_size_in, alu_result_in[1:0]);
    assign start      = (state_q == StIdle) & access & ~misaligned;

    // Saturating so a late acceptance cannot wrap the count back below the limit.
    assign cnt_inc = (cnt_q == {TIMEOUT_W{1'b1}}) ? cnt_q : cnt_q + TIMEOUT_W'(1);
    // cnt_q counts completed REQ/RESP cycles, so this is the TIMEOUT-th one.
    assign timeout = cnt_q >= TimeoutLast;

    lsu_align u_align (
        .st_size_i     (mem_size_in),
        .st_off_i      (alu_result_in[1:0]),
        .st_data_i     (write_data_in),
        .st_wdata_o    (st_wdata),
        .st_wstrb_o    (st_wstrb),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_unsigned_i (uns_q),
        .ld_rdata_i    (dmem_rdata),
        .ld_data_o     (ld_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= WSTRB_NONE;
            size_q     <= MEM_BYTE;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            cnt_q      <= '0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            ld_valid_q <= 1'b0;
            berr_q     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StReq;
                        req_q   <= 1'b1;
                        // A store wins when both flags are set.
                        we_q    <= store_enable_in;
                        addr_q  <= {alu_result_in[31:2], 2'b00};
                        wdata_q <= store_enable_in ? st_wdata : '0;
                        wstrb_q <= store_enable_in ? st_wstrb : WSTRB_NONE;
                        size_q  <= mem_size_in;
                        uns_q   <= is_unsigned_in;
                        off_q   <= alu_result_in[1:0];
                        cnt_q   <= '0;
                    end
                end
                StReq: begin
                    if (dmem_ready) begin
                        req_q   <= 1'b0;
                        state_q <= we_q ? StDone : StResp;
                        cnt_q   <= cnt_inc;
                    end else if (timeout) begin
                        req_q     <= 1'b0;
                        state_q   <= StDone;
                        berr_q    <= 1'b1;
                        ld_data_q <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StResp: begin
                    if (dmem_rvalid) begin
                        ld_data_q  <= ld_ext;
                        ld_valid_q <= 1'b1;
                        state_q    <= StDone;
                    end else if (timeout) begin
                        state_q   <= StDone;
                        berr_q    <= 1'b1;
                        ld_data_q <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign dmem_wstrb     = wstrb_q;
    assign load_data_out  = ld_data_q;
    assign load_valid     = ld_valid_q;
    assign bus_error      = berr_q;
    assign mem_stall      = start | (state_q == StReq) | (state_q == StResp);
    assign misaligned_exc = (state_q == StIdle) & access & misaligned;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a transaction-level reference model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_to_reg_in;
    logic        store_enable_in;
    logic        is_unsigned_in;
    logic [1:0]  mem_size_in;
    logic [31:0] alu_result_in;
    logic [31:0] write_data_in;
    logic        dmem_req;
    logic        dmem_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data_out;
    logic        load_valid;
    logic        mem_stall;
    logic        misaligned_exc;
    logic        bus_error;

    int vectors     = 0;
    int miscompares = 0;

    // Descriptor of the access currently being driven; the model works from this.
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wd;
    logic [31:0] cur_rdata;
    logic [1:0]  cur_size;
    logic        cur_uns;
    logic        lv_allowed;

    always #5 clk = ~clk;

    mem_stage_lsu #(
        .TIMEOUT_W (8),
        .TIMEOUT   (255)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_to_reg_in   (mem_to_reg_in),
        .store_enable_in (store_enable_in),
        .is_unsigned_in  (is_unsigned_in),
        .mem_size_in     (mem_size_in),
        .alu_result_in   (alu_result_in),
        .write_data_in   (write_data_in),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_wstrb      (dmem_wstrb),
        .dmem_rvalid     (dmem_rvalid),
        .dmem_rdata      (dmem_rdata),
        .load_data_out   (load_data_out),
        .load_valid      (load_valid),
        .mem_stall       (mem_stall),
        .misaligned_exc  (misaligned_exc),
        .bus_error       (bus_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---- reference model ----
    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'd0:    return {24'd0, wd[7:0]} * 32'h0101_0101;
            2'd1:    return {16'd0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [1:0] size, input logic [31:0] addr);
        int off;
        off = int'(addr % 4);
        case (size)
            2'd0:    return 4'(1 << off);
            2'd1:    return (off >= 2) ? 4'b1100 : 4'b0011;
            2'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rdata);
        longint w;
        longint v;
        int     n;
        w = longint'({32'd0, rdata}) / (longint'(1) << (8 * int'(addr % 4)));
        n = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
        v = w % (longint'(1) << n);
        if (!uns && v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
        return v[31:0];
    endfunction

    // ---- per-cycle compare against the model ----
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && dmem_req) begin
                check("req_we", {31'd0, dmem_we}, {31'd0, cur_we});
                check("req_addr", dmem_addr, cur_addr & 32'hFFFF_FFFC);
                check("req_wstrb", {28'd0, dmem_wstrb},
                      cur_we ? {28'd0, m_wstrb(cur_size, cur_addr)} : 32'd0);
                if (cur_we) check("req_wdata", dmem_wdata, m_wdata(cur_size, cur_wd));
            end
            if (load_valid && lv_allowed)
                check("load_result", load_data_out, m_load(cur_size, cur_uns, cur_addr, cur_rdata));
            if (!lv_allowed) check("spurious_load_valid", {31'd0, load_valid}, 32'd0);
        end
    end

    // Drives one access until the unit releases the stall; rdy_dly = request cycles
    // before ready, rv_dly = cycles after the first allowed rvalid slot (<0: never).
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wd, input logic [31:0] rdata,
                              input int rdy_dly, input int rv_dly,
                              output int stalls, output int lv_cnt, output logic berr,
                              output logic [31:0] fa, output logic [31:0] fwd,
                              output logic [3:0] fst, output int chg);
        int   req_seen;
        int   acc_cyc;
        logic done;
        logic fwe;
        req_seen = 0;
        acc_cyc  = -1;
        done     = 1'b0;
        fwe      = 1'b0;
        stalls   = 0;
        lv_cnt   = 0;
        berr     = 1'b0;
        fa       = '0;
        fwd      = '0;
        fst      = '0;
        chg      = 0;
        @(negedge clk);
        cur_we = we; cur_addr = addr; cur_size = size; cur_uns = uns;
        cur_wd = wd; cur_rdata = rdata; lv_allowed = !we;
        mem_to_reg_in   = !we;
        store_enable_in = we;
        is_unsigned_in  = uns;
        mem_size_in     = size;
        alu_result_in   = addr;
        write_data_in   = wd;
        dmem_rdata      = rdata;
        for (int cyc = 0; cyc < 400; cyc++) begin
            dmem_ready  = dmem_req && (req_seen >= rdy_dly);
            dmem_rvalid = (acc_cyc >= 0) && (rv_dly >= 0) && (cyc == acc_cyc + 1 + rv_dly);
            #1;
            if (dmem_req) begin
                if (req_seen == 0) begin
                    fa = dmem_addr; fwd = dmem_wdata; fst = dmem_wstrb; fwe = dmem_we;
                end else if (dmem_addr !== fa || dmem_wdata !== fwd || dmem_wstrb !== fst ||
                             dmem_we !== fwe) begin
                    chg++;
                end
                req_seen++;
                if (dmem_ready) acc_cyc = cyc;
            end
            if (load_valid) lv_cnt++;
            if (bus_error) berr = 1'b1;
            if (mem_stall) stalls++;
            else begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        mem_to_reg_in   = 1'b0;
        store_enable_in = 1'b0;
        dmem_ready      = 1'b0;
        dmem_rvalid     = 1'b0;
        check("access_completes", {31'd0, done}, 32'd1);
        // load_valid must be a single-cycle pulse
        @(negedge clk);
        #1;
        if (load_valid) lv_cnt++;
        lv_allowed = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int          st;
        int          lv;
        int          chg;
        int          lvc;
        logic        be;
        logic [31:0] fa;
        logic [31:0] fwd;
        logic [3:0]  fst;

        rst = 1'b1; mem_to_reg_in = 1'b0; store_enable_in = 1'b0; is_unsigned_in = 1'b0;
        mem_size_in = 2'd0; alu_result_in = '0; write_data_in = '0; dmem_ready = 1'b0;
        dmem_rvalid = 1'b0; dmem_rdata = '0; lv_allowed = 1'b0;
        cur_we = 1'b0; cur_addr = '0; cur_wd = '0; cur_rdata = '0; cur_size = 2'd0; cur_uns = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_dmem_wstrb", {28'd0, dmem_wstrb}, 32'd0);
        check("rst_load_valid", {31'd0, load_valid}, 32'd0);
        check("rst_bus_error", {31'd0, bus_error}, 32'd0);
        check("rst_load_data", load_data_out, 32'd0);
        check("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
        rst = 1'b0;

        // store word, immediate ready
        run_access(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'd0, 0, 0, st, lv, be, fa, fwd, fst, chg);
        check("sw_stalls", st, 2);
        check("sw_addr", fa, 32'h100);
        check("sw_wstrb", {28'd0, fst}, 32'hF);
        check("sw_wdata", fwd, 32'hDEAD_BEEF);
        check("sw_no_load_valid", lv, 0);

        // store byte @0x103
        run_access(1'b1, 32'h103, 2'd0, 1'b0, 32'h1234_56A5, 32'd0, 0, 0, st, lv, be, fa, fwd, fst, chg);
        check("sb_addr", fa, 32'h100);
        check("sb_wdata", fwd, 32'hA5A5_A5A5);
        check("sb_wstrb", {28'd0, fst}, 32'h8);
        check("sb_stalls", st, 2);

        // store half @0x106
        run_access(1'b1, 32'h106, 2'd1, 1'b0, 32'hCAFE_BEEF, 32'd0, 0, 0, st, lv, be, fa, fwd, fst, chg);
        check("sh_addr", fa, 32'h104);
        check("sh_wdata", fwd, 32'hBEEF_BEEF);
        check("sh_wstrb", {28'd0, fst}, 32'hC);

        // load byte signed/unsigned @0x102
        run_access(1'b0, 32'h102, 2'd0, 1'b0, 32'd0, 32'h0080_0000, 0, 0, st, lv, be, fa, fwd, fst, chg);
        check("lb_stalls", st, 3);
        check("lb_valid_pulses", lv, 1);
        check("lb_data", load_data_out, 32'hFFFF_FF80);
        check("lb_wstrb", {28'd0, fst}, 32'h0);
        run_access(1'b0, 32'h102, 2'd0, 1'b1, 32'd0, 32'h0080_0000, 0, 0, st, lv, be, fa, fwd, fst, chg);
        check("lbu_data", load_data_out, 32'h0000_0080);

        // load half signed @0x102, load word @0x108
        run_access(1'b0, 32'h102, 2'd1, 1'b0, 32'd0, 32'h8001_1234, 0, 0, st, lv, be, fa, fwd, fst, chg);
        check("lh_data", load_data_out, 32'hFFFF_8001);
        run_access(1'b0, 32'h108, 2'd2, 1'b0, 32'd0, 32'h1234_5678, 0, 2, st, lv, be, fa, fwd, fst, chg);
        check("lw_data", load_data_out, 32'h1234_5678);
        check("lw_stalls_rvalid_late", st, 5);

        // misaligned / reserved size: no bus activity, no stall
        @(negedge clk);
        mem_to_reg_in = 1'b1; mem_size_in = 2'd1; alu_result_in = 32'h101;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mis_lh_exc", {31'd0, misaligned_exc}, 32'd1);
            check("mis_lh_stall", {31'd0, mem_stall}, 32'd0);
            check("mis_lh_req", {31'd0, dmem_req}, 32'd0);
            @(negedge clk);
        end
        mem_to_reg_in = 1'b0; store_enable_in = 1'b1; mem_size_in = 2'd3; alu_result_in = 32'h100;
        #1;
        check("mis_size3_exc", {31'd0, misaligned_exc}, 32'd1);
        @(negedge clk);
        mem_size_in = 2'd2; alu_result_in = 32'h102;
        #1;
        check("mis_sw_exc", {31'd0, misaligned_exc}, 32'd1);
        @(negedge clk);
        #1;
        check("mis_sw_no_req", {31'd0, dmem_req}, 32'd0);
        store_enable_in = 1'b0;
        #1;
        check("mis_clear", {31'd0, misaligned_exc}, 32'd0);

        // ready held low for 5 request cycles
        run_access(1'b0, 32'h10C, 2'd2, 1'b0, 32'd0, 32'hA1B2_C3D4, 5, 0, st, lv, be, fa, fwd, fst, chg);
        check("slow_ready_stalls", st, 8);
        check("slow_ready_stable", chg, 0);
        check("slow_ready_data", load_data_out, 32'hA1B2_C3D4);

        // load result holds across a store
        run_access(1'b1, 32'h120, 2'd2, 1'b0, 32'h5555_AAAA, 32'd0, 0, 0, st, lv, be, fa, fwd, fst, chg);
        check("load_data_hold", load_data_out, 32'hA1B2_C3D4);

        // watchdog: rvalid never comes
        run_access(1'b0, 32'h110, 2'd2, 1'b0, 32'd0, 32'h0BAD_0BAD, 0, -1, st, lv, be, fa, fwd, fst, chg);
        check("wd_bus_error", {31'd0, be}, 32'd1);
        check("wd_stalls", st, 256);
        check("wd_no_load_valid", lv, 0);
        check("wd_load_data_zero", load_data_out, 32'd0);
        check("wd_bus_error_pulse", {31'd0, bus_error}, 32'd0);
        check("wd_req_dropped", {31'd0, dmem_req}, 32'd0);

        // reset while waiting for rvalid
        @(negedge clk);
        cur_we = 1'b0; cur_addr = 32'h114; cur_size = 2'd2; cur_uns = 1'b0; cur_rdata = 32'h7777_7777;
        mem_to_reg_in = 1'b1; mem_size_in = 2'd2; alu_result_in = 32'h114; dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        dmem_ready = dmem_req;
        #1;
        check("rstmid_req_up", {31'd0, dmem_req}, 32'd1);
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        check("rstmid_in_resp_stall", {31'd0, mem_stall}, 32'd1);
        rst = 1'b1; mem_to_reg_in = 1'b0;
        @(negedge clk);
        #1;
        check("rstmid_req_low", {31'd0, dmem_req}, 32'd0);
        check("rstmid_idle", {31'd0, mem_stall}, 32'd0);
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        lvc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (load_valid) lvc++;
        end
        dmem_rvalid = 1'b0;
        check("rstmid_stale_rvalid", lvc, 0);
        check("rstmid_load_data", load_data_out, 32'd0);

        // unit is usable after the abort
        run_access(1'b0, 32'h117, 2'd0, 1'b1, 32'd0, 32'h7F00_0000, 0, 0, st, lv, be, fa, fwd, fst, chg);
        check("post_rst_lbu", load_data_out, 32'h0000_007F);
        check("post_rst_pulses", lv, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

MEM-stage load/store unit consuming the control and data fields latched by the EX/MEM pipeline register. It turns a load or store into a valid/ready transaction on the data-memory port, and aligns byte/half/word data in both directions. While the access is outstanding it drives `mem_stall` to the hazard unit, then presents the load result to the MEM/WB register.

## Interface
- `TIMEOUT_W`, default 8: width of the response watchdog counter.
- `TIMEOUT`, default 255: cycles allowed in REQ+RESP before abort.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_to_reg_in` in 1: instruction is a load.
- `store_enable_in` in 1: instruction is a store.
- `is_unsigned_in` in 1: zero-extend load (else sign-extend).
- `mem_size_in` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `alu_result_in` in 32: effective byte address.
- `write_data_in` in 32: store data, value in low bits.
- `dmem_req` out 1: request valid.
- `dmem_ready` in 1: request accepted when `dmem_req & dmem_ready`.
- `dmem_we` out 1: 1 store, 0 load.
- `dmem_addr` out 32: word address, bits [1:0] = 0.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_wstrb` out 4: byte enables, 0000 for loads.
- `dmem_rvalid` in 1: load data valid.
- `dmem_rdata` in 32: raw load word.
- `load_data_out` out 32: extended load result.
- `load_valid` out 1: one-cycle pulse with result.
- `mem_stall` out 1: freeze PC, IF/ID, ID/EX, EX/MEM.
- `misaligned_exc` out 1: misaligned or reserved-size access.
- `bus_error` out 1: watchdog abort pulse.

## Operation
- `access = mem_to_reg_in | store_enable_in`. If both flags are set, the store takes priority.
- Misaligned cases:
  - half with addr[0] = 1
  - word with addr[1:0] ≠ 0
  - size 11
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE → REQ when access & !misaligned. Latch address, we, wdata, wstrb, size, unsigned, byte offset.
  - IDLE with access & misaligned: `misaligned_exc` = 1 combinationally, no bus activity, `mem_stall` = 0, stay IDLE.
  - REQ: `dmem_req` = 1, held with stable fields until `dmem_ready`. Ready with a store → DONE. Ready with a load → RESP.
  - RESP: wait for `dmem_rvalid`, register the extended data, → DONE.
  - DONE: one cycle, `mem_stall` = 0, `load_valid` = (load) → IDLE.
- `mem_stall` = (IDLE & access & !misaligned) | REQ | RESP. Upstream holds EX/MEM stable while it is high.
- Store lanes:
  - byte: wstrb = 0001 << off, wdata = {4{wd[7:0]}}
  - half: wstrb = off[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}
  - word: wstrb = 1111, wdata = wd
- Load extract: shift rdata right by 8*off, take 8/16/32 bits, then zero- or sign-extend to 32 bits.
- Watchdog:
  - Counter clears on entry to REQ and increments in REQ/RESP.
  - On reaching TIMEOUT: `bus_error` pulse, `dmem_req` drops, → DONE with `load_valid` = 0 and `load_data_out` = 0.
- `dmem_rvalid` outside RESP is ignored.

## Timing
- Reset values:
  - state IDLE
  - `dmem_req`, `dmem_we`, `load_valid`, `bus_error` = 0
  - `dmem_addr`, `dmem_wdata`, `load_data_out` = 0
  - `dmem_wstrb` = 0000
- `dmem_*` outputs are registered. `mem_stall` and `misaligned_exc` are combinational from state and inputs.
- Store with immediate ready: 2 stall cycles (IDLE, REQ), DONE on the 3rd cycle.
- Load with ready at t and rvalid at t+1: 3 stall cycles. `load_valid` appears in the cycle after rvalid.
- The responder asserts `rvalid` no earlier than one cycle after acceptance.
- `rst` mid-access aborts at the next edge: `dmem_req` = 0, no `load_valid`; stale rvalid is ignored.
- `load_data_out` holds its value until the next load completes.

## Structure
- `riscv_pkg` holds:
  - MEM_BYTE/HALF/WORD encodings
  - the `lsu_state_t` enum
  - the WSTRB constants
- Sub-module `lsu_align` (combinational) holds store lane replication/strobe and load extract/extend. It is shared with any future cache.

## Test plan
- Store word 0xDEADBEEF @0x100, ready immediate → addr 0x100, wstrb 1111, stall 2 cycles, no `load_valid`.
- Store byte 0xA5 @0x103 → wdata 0xA5A5A5A5, wstrb 1000.
- Load byte signed @0x102, rdata 0x00800000, rvalid 1 cycle after ready → `load_data_out` 0xFFFFFF80, `load_valid` one pulse; unsigned → 0x00000080.
- Load half @0x101 → `misaligned_exc` = 1, `dmem_req` never asserted, `mem_stall` = 0.
- Load with ready low 5 cycles → `dmem_req` and fields stable throughout; with rvalid never asserted → `bus_error` after 255 cycles, stall releases.
- `rst` asserted in RESP → next cycle IDLE, `dmem_req` = 0; a later rvalid produces no `load_valid`.
